// File: rtl/imm_extend_arbiter.sv
// imm_extend_arbiter
// Two decode lanes share one immediate extraction / sign-extension datapath.
// A round-robin arbiter picks one lane per cycle. The chosen immediate is
// decoded, extended to 64 bits and registered toward rename/dispatch behind a
// valid/ready handshake. Sustained throughput is one immediate per cycle.
//
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   req{0,1}_valid        lane has an instruction that needs an immediate
//   req{0,1}_ready        lane request accepted this cycle (combinational)
//   req{0,1}_instr        32-bit instruction word
//   req{0,1}_fmt          immediate format select (0..5 legal, 6/7 illegal)
//   req{0,1}_tag          ROB/dispatch tag carried with the request
//   out_valid/out_ready   result handshake
//   out_imm               64-bit extended immediate
//   out_tag, out_src      tag and originating lane of the result
//   out_err               result came from an illegal format code
//   illegal_cnt           saturating count of accepted illegal requests
module imm_extend_arbiter #(
    parameter int TAG_W        = 6,
    parameter bit SHIFT_BRANCH = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [31:0]      req0_instr,
    input  logic [2:0]       req0_fmt,
    input  logic [TAG_W-1:0] req0_tag,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [31:0]      req1_instr,
    input  logic [2:0]       req1_fmt,
    input  logic [TAG_W-1:0] req1_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_imm,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_src,
    output logic             out_err,
    output logic [7:0]       illegal_cnt
);

    logic             rr_ptr;
    logic             load_en;
    logic             grant0;
    logic             grant1;
    logic             accept0;
    logic             accept1;
    logic             accept;
    logic [31:0]      sel_instr;
    logic [2:0]       sel_fmt;
    logic [TAG_W-1:0] sel_tag;
    logic [63:0]      dec_imm;
    logic             dec_err;

    // The output stage can take a new result when it is empty or its current
    // result is being consumed this cycle. A lane only wins outright when the
    // other lane is idle; on contention rr_ptr decides. Readies are forced low
    // during reset so nothing is accepted into a register that is being cleared.
    always_comb begin
        load_en    = !out_valid || out_ready;
        grant0     = req0_valid && (!req1_valid || !rr_ptr);
        grant1     = req1_valid && (!req0_valid || rr_ptr);
        req0_ready = !reset && load_en && grant0;
        req1_ready = !reset && load_en && grant1;
        accept0    = req0_valid && req0_ready;
        accept1    = req1_valid && req1_ready;
        accept     = accept0 || accept1;
    end

    // Steer the granted lane into the shared decoder. Lane 0 is the default
    // so the mux has a defined value even when nobody is accepted.
    always_comb begin
        sel_instr = req0_instr;
        sel_fmt   = req0_fmt;
        sel_tag   = req0_tag;
        if (accept1) begin
            sel_instr = req1_instr;
            sel_fmt   = req1_fmt;
            sel_tag   = req1_tag;
        end
    end

    // Shared immediate decoder. Each field is first widened to 64 bits so any
    // following shift drops bits past bit 63 instead of wrapping. IW shifts by
    // 16 times the 2-bit halfword selector. Illegal formats yield zero + error.
    always_comb begin
        dec_imm = 64'd0;
        dec_err = 1'b0;
        case (sel_fmt)
            3'd0: dec_imm = {{55{sel_instr[20]}}, sel_instr[20:12]};
            3'd1: dec_imm = {52'd0, sel_instr[21:10]};
            3'd2: begin
                dec_imm = {{45{sel_instr[23]}}, sel_instr[23:5]};
                if (SHIFT_BRANCH) dec_imm = dec_imm << 2;
            end
            3'd3: begin
                dec_imm = {{38{sel_instr[25]}}, sel_instr[25:0]};
                if (SHIFT_BRANCH) dec_imm = dec_imm << 2;
            end
            3'd4: dec_imm = {48'd0, sel_instr[20:5]} << {sel_instr[22:21], 4'd0};
            3'd5: dec_imm = {58'd0, sel_instr[15:10]};
            default: begin
                dec_imm = 64'd0;
                dec_err = 1'b1;
            end
        endcase
    end

    // Output register and arbitration pointer. On an accept the result loads
    // and the pointer moves to the lane that did not win. With no accept a
    // consumed result simply drops valid, leaving stale data in place. A stall
    // holds everything because load_en keeps the readies low.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid   <= 1'b0;
            out_imm     <= 64'd0;
            out_tag     <= '0;
            out_src     <= 1'b0;
            out_err     <= 1'b0;
            illegal_cnt <= 8'd0;
            rr_ptr      <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_imm   <= dec_imm;
            out_tag   <= sel_tag;
            out_src   <= accept1;
            out_err   <= dec_err;
            rr_ptr    <= accept0;
            if (dec_err && illegal_cnt != 8'hFF) begin
                illegal_cnt <= illegal_cnt + 8'd1;
            end
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_imm_extend_arbiter.sv
// Directed testbench for imm_extend_arbiter. Inputs are driven 1 time unit
// after a rising edge; readies are sampled once they settle and registered
// outputs are sampled 1 time unit after the following rising edge.
module tb_imm_extend_arbiter;

    localparam int TAG_W = 6;

    logic             clk = 1'b0;
    logic             reset;
    logic             req0_valid;
    logic             req0_ready;
    logic [31:0]      req0_instr;
    logic [2:0]       req0_fmt;
    logic [TAG_W-1:0] req0_tag;
    logic             req1_valid;
    logic             req1_ready;
    logic [31:0]      req1_instr;
    logic [2:0]       req1_fmt;
    logic [TAG_W-1:0] req1_tag;
    logic             out_valid;
    logic             out_ready;
    logic [63:0]      out_imm;
    logic [TAG_W-1:0] out_tag;
    logic             out_src;
    logic             out_err;
    logic [7:0]       illegal_cnt;

    int checks   = 0;
    int failures = 0;
    logic [31:0] instr;
    logic [63:0] held_imm;

    imm_extend_arbiter #(.TAG_W(TAG_W), .SHIFT_BRANCH(1'b1)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_instr(req0_instr),
        .req0_fmt(req0_fmt), .req0_tag(req0_tag),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_instr(req1_instr),
        .req1_fmt(req1_fmt), .req1_tag(req1_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
        .out_tag(out_tag), .out_src(out_src), .out_err(out_err),
        .illegal_cnt(illegal_cnt)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    // Advance one rising edge and step just past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One comparison: counts it, and on mismatch counts and reports the failure.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Drive lane 0 with a request; lane 1 idle.
    task automatic applyStimulus(input logic [31:0] i, input logic [2:0] f,
                                 input logic [TAG_W-1:0] t);
        req0_valid = 1'b1;
        req0_instr = i;
        req0_fmt   = f;
        req0_tag   = t;
        req1_valid = 1'b0;
    endtask

    // Directed sequence: reset, single lane, alternation, formats,
    // backpressure, illegal saturation, reset during a stall.
    initial begin
        reset = 1'b1;
        req0_valid = 1'b1; req0_instr = 32'h0; req0_fmt = 3'd0; req0_tag = '0;
        req1_valid = 1'b1; req1_instr = 32'h0; req1_fmt = 3'd0; req1_tag = '0;
        out_ready = 1'b1;
        tick();
        tick();
        checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset_out_imm", out_imm, 64'd0);
        checkOutput("reset_out_tag", 64'(out_tag), 64'd0);
        checkOutput("reset_out_src_err", {62'd0, out_src, out_err}, 64'd0);
        checkOutput("reset_illegal_cnt", 64'(illegal_cnt), 64'd0);
        checkOutput("reset_readies", {62'd0, req0_ready, req1_ready}, 64'd0);
        reset = 1'b0;

        // Lane 0 only, D-type, surrounding bits set to catch bad extraction.
        instr = 32'hFFE00FFF;
        instr[20:12] = 9'h1F0;
        applyStimulus(instr, 3'd0, 6'd5);
        #1;
        checkOutput("d_ready0", 64'(req0_ready), 64'd1);
        tick();
        req0_valid = 1'b0;
        checkOutput("d_valid", 64'(out_valid), 64'd1);
        checkOutput("d_imm", out_imm, 64'hFFFF_FFFF_FFFF_FFF0);
        checkOutput("d_tag", 64'(out_tag), 64'd5);
        checkOutput("d_src_err", {62'd0, out_src, out_err}, 64'd0);
        tick();
        checkOutput("drain_valid", 64'(out_valid), 64'd0);
        checkOutput("drain_stale_imm", out_imm, 64'hFFFF_FFFF_FFFF_FFF0);

        // Both lanes valid after reset: grants alternate 0,1,0,1.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        instr = 32'h0; instr[15:10] = 6'h2A;
        req0_valid = 1'b1; req0_instr = instr; req0_fmt = 3'd5; req0_tag = 6'd10;
        instr = 32'h0; instr[15:10] = 6'h15;
        req1_valid = 1'b1; req1_instr = instr; req1_fmt = 3'd5; req1_tag = 6'd20;
        for (int i = 0; i < 4; i++) begin
            #1;
            checkOutput("alt_readies", {62'd0, req0_ready, req1_ready},
                        (i % 2 == 0) ? 64'd2 : 64'd1);
            tick();
            checkOutput("alt_valid", 64'(out_valid), 64'd1);
            checkOutput("alt_src", 64'(out_src), 64'(i % 2));
            checkOutput("alt_tag", 64'(out_tag), (i % 2 == 0) ? 64'd10 : 64'd20);
            checkOutput("alt_imm", out_imm, (i % 2 == 0) ? 64'h2A : 64'h15);
        end

        // Format coverage on lane 0.
        instr = 32'h0; instr[25:0] = 26'h3FFFFFF;
        applyStimulus(instr, 3'd3, 6'd1);
        tick();
        checkOutput("b_neg_imm", out_imm, 64'hFFFF_FFFF_FFFF_FFFC);
        instr = 32'hFF00001F; instr[23:5] = 19'h00001;
        applyStimulus(instr, 3'd2, 6'd2);
        tick();
        checkOutput("cb_pos_imm", out_imm, 64'h4);
        instr = 32'h0; instr[23:5] = 19'h40000;
        applyStimulus(instr, 3'd2, 6'd3);
        tick();
        checkOutput("cb_neg_imm", out_imm, 64'hFFFF_FFFF_FFF0_0000);
        instr = 32'h0; instr[20:5] = 16'hBEEF; instr[22:21] = 2'b11;
        applyStimulus(instr, 3'd4, 6'd4);
        tick();
        checkOutput("iw_hw3_imm", out_imm, 64'hBEEF_0000_0000_0000);
        instr = 32'h0; instr[20:5] = 16'h1234; instr[22:21] = 2'b01;
        applyStimulus(instr, 3'd4, 6'd5);
        tick();
        checkOutput("iw_hw1_imm", out_imm, 64'h1234_0000);
        instr = 32'hFFC003FF; instr[21:10] = 12'hFFF;
        applyStimulus(instr, 3'd1, 6'd6);
        tick();
        checkOutput("i_imm", out_imm, 64'hFFF);
        checkOutput("i_err", 64'(out_err), 64'd0);
        instr = 32'h0; instr[20:12] = 9'h0FF;
        applyStimulus(instr, 3'd0, 6'd7);
        tick();
        checkOutput("d_pos_imm", out_imm, 64'hFF);
        checkOutput("d_pos_tag", 64'(out_tag), 64'd7);
        held_imm = out_imm;

        // Backpressure with both lanes valid; last winner was lane 0 so
        // lane 1 must be next once the consumer frees up.
        out_ready = 1'b0;
        req1_valid = 1'b1; req1_instr = 32'h0; req1_fmt = 3'd5; req1_tag = 6'd33;
        for (int i = 0; i < 3; i++) begin
            #1;
            checkOutput("stall_readies", {62'd0, req0_ready, req1_ready}, 64'd0);
            tick();
            checkOutput("stall_valid", 64'(out_valid), 64'd1);
            checkOutput("stall_imm", out_imm, held_imm);
            checkOutput("stall_tag", 64'(out_tag), 64'd7);
        end
        out_ready = 1'b1;
        #1;
        checkOutput("release_readies", {62'd0, req0_ready, req1_ready}, 64'd1);
        tick();
        checkOutput("release_valid", 64'(out_valid), 64'd1);
        checkOutput("release_src", 64'(out_src), 64'd1);
        checkOutput("release_tag", 64'(out_tag), 64'd33);

        // 300 illegal requests: each errors with zero immediate, count saturates.
        applyStimulus(32'hFFFF_FFFF, 3'd7, 6'd9);
        for (int i = 0; i < 300; i++) begin
            tick();
            checkOutput("illegal_err", 64'(out_err), 64'd1);
            checkOutput("illegal_imm", out_imm, 64'd0);
            if (i == 99) checkOutput("illegal_cnt_100", 64'(illegal_cnt), 64'd100);
        end
        checkOutput("illegal_cnt_sat", 64'(illegal_cnt), 64'd255);

        // Stall, then reset during the stall drops the pending result.
        out_ready = 1'b0;
        tick();
        tick();
        checkOutput("pre_reset_valid", 64'(out_valid), 64'd1);
        reset = 1'b1;
        req1_valid = 1'b1;
        out_ready = 1'b1;
        #1;
        checkOutput("reset_hold_readies", {62'd0, req0_ready, req1_ready}, 64'd0);
        tick();
        checkOutput("midstall_reset_valid", 64'(out_valid), 64'd0);
        checkOutput("midstall_reset_cnt", 64'(illegal_cnt), 64'd0);
        reset = 1'b0;
        #1;
        checkOutput("post_reset_ptr", {62'd0, req0_ready, req1_ready}, 64'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/imm_extend_arbiter.md
Name: imm_extend_arbiter

Overview:
- Shares one immediate-extraction/sign-extension datapath between the two decode lanes of the out-of-order front end.
- Each cycle, round-robin arbitration picks one lane's instruction.
- The selected immediate field is extracted, extended to 64 bits and registered toward the rename/dispatch stage.
- Output uses a valid/ready handshake with backpressure; throughput is one immediate per cycle.

Parameters:
TAG_W, 6, width of the ROB/dispatch tag carried alongside each request
SHIFT_BRANCH, 1, when 1, CB/B offsets are shifted left by 2 after extension; when 0, they are not shifted

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
req0_valid  in  1  lane 0 has an instruction needing an immediate
req0_ready  out  1  lane 0 request accepted this cycle
req0_instr  in  32  lane 0 instruction word
req0_fmt  in  3  lane 0 immediate format select
req0_tag  in  TAG_W  lane 0 tag
req1_valid, req1_ready, req1_instr, req1_fmt, req1_tag  as lane 0, for lane 1
out_valid  out  1  out_imm/out_tag/out_src/out_err hold a valid result
out_ready  in  1  consumer accepts the result
out_imm  out  64  extended immediate
out_tag  out  TAG_W  tag of the request that produced out_imm
out_src  out  1  lane that produced the result (0/1)
out_err  out  1  request had an illegal format code
illegal_cnt  out  8  saturating count of accepted illegal-format requests

Behaviour:
- Reset, synchronous: out_valid=0, out_imm=0, out_tag=0, out_src=0, out_err=0, illegal_cnt=0, rr_ptr=0 (lane 0 has priority).
- req*_ready are combinational and are 0 while reset=1.
- load_en = !out_valid || out_ready.
- Grant when both lanes are valid: lane rr_ptr wins.
- Grant when one lane is valid: that lane wins.
- req0_ready = load_en & grant0; req1_ready = load_en & grant1. At most one ready is high per cycle.
- Accepted request = valid & ready on a lane.
- On accept:
  - Output registers load the next cycle (latency 1); out_valid=1.
  - rr_ptr becomes the non-granted lane.
  - rr_ptr is unchanged when nothing is accepted.
- If out_valid & out_ready and there is no accept: out_valid clears. out_imm and out_tag hold their stale values.
- Back-to-back operation: out_valid stays 1 when a new accept coincides with consumption.
- While stalled (out_valid & !out_ready): output registers hold; no ready is asserted; rr_ptr holds.
- Format decode (I = instruction word):
  - 0 D-type: I[20:12], sign-extended from bit 8.
  - 1 I-type: I[21:10], zero-extended.
  - 2 CB: I[23:5], sign-extended from bit 18, then <<2 if SHIFT_BRANCH.
  - 3 B: I[25:0], sign-extended from bit 25, then <<2 if SHIFT_BRANCH.
  - 4 IW: I[20:5], zero-extended, then << (16*I[22:21]).
  - 5 shamt: I[15:10], zero-extended.
  - 6, 7 illegal: out_imm=0, out_err=1.
- out_err=0 for all legal formats.
- illegal_cnt increments on each accepted illegal request and saturates at 255.
- Shift width rule: shifts are performed on the 64-bit value; bits shifted past bit 63 are discarded.
- Reset asserted mid-stall: the pending output is dropped (out_valid=0); rr_ptr returns to 0.

Test Plan:
- Lane 0 only: fmt0, I[20:12]=9'h1F0, out_ready=1 → next cycle out_valid=1, out_imm=64'hFFFFFFFFFFFFFFF0, out_src=0, out_err=0.
- Both lanes valid every cycle, out_ready=1, after reset → grants alternate 0,1,0,1. Each output cycle out_src matches and out_tag equals the granted lane's tag.
- B-type, I[25:0]=26'h3FFFFFF, SHIFT_BRANCH=1 → out_imm=64'hFFFFFFFFFFFFFFFC. CB with I[23:5]=19'h00001 → out_imm=64'h4.
- IW: I[20:5]=16'hBEEF, I[22:21]=2'b11 → out_imm=64'hBEEF000000000000. I-type with I[21:10]=12'hFFF → out_imm=64'hFFF.
- Backpressure: out_ready=0 for 3 cycles with both lanes valid → req0_ready=req1_ready=0, outputs stable, rr_ptr unchanged. Release out_ready → the lane pointed to by rr_ptr is accepted next.
- Illegal: 300 accepted fmt7 requests → each has out_err=1 and out_imm=0; illegal_cnt=255. Asserting reset mid-stall → out_valid=0 and illegal_cnt=0 next cycle.
